// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one FP add/sub unit between NUM_REQ requesters.
// Requesters are granted round-robin. Each grant issues an operand pair to the
// adder and pushes the requester ID into a tag FIFO. Adder results, which come
// back in issue order, are paired with their tags and buffered. They are then
// returned in order on one valid/ready response channel.
// Optional statistics counters are enabled with the macro FP_ADD_ARB_STATS_EN.
//
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   req_valid/req_ready        per-requester handshake (one ready max per cycle)
//   req_op_a/req_op_b/req_sub  packed per-requester operands and subtract select
//   add_start/add_a/add_b/add_op  issue interface to the adder
//   add_done/add_result        adder completion strobe and result
//   rsp_valid/rsp_ready/rsp_id/rsp_data  in-order response channel
//   flush/flush_done           drain request (level) and completion pulse
//   err_spurious               sticky: add_done seen with nothing in flight
//   stat_clr/stat_issued/stat_stall  (FP_ADD_ARB_STATS_EN only) counters
module fp_add_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned RES_DEPTH = 8,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_op_b,
  input  logic [NUM_REQ-1:0]        req_sub,
  output logic                      add_start,
  output logic [DATA_W-1:0]         add_a,
  output logic [DATA_W-1:0]         add_b,
  output logic                      add_op,
  input  logic                      add_done,
  input  logic [DATA_W-1:0]         add_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      flush,
  output logic                      flush_done,
`ifdef FP_ADD_ARB_STATS_EN
  input  logic                      stat_clr,
  output logic [31:0]               stat_issued,
  output logic [31:0]               stat_stall,
`endif
  output logic                      err_spurious
);

  localparam int unsigned CNT_W = $clog2(RES_DEPTH + 1);
  localparam int unsigned PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int unsigned RR_W  = $clog2(NUM_REQ);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } state_e;

  state_e            state, state_nxt;
  logic [RR_W-1:0]   rr_ptr, grant_idx, cand;
  logic              grant_vld, grant_en, credit_ok, accept;
  logic [CNT_W-1:0]  inflight, inflight_nxt, res_count, res_count_nxt;
  logic [PTR_W-1:0]  tag_wr, tag_rd, res_wr, res_rd;
  logic              done_ok, done_bad, rsp_pop, drain_empty, flush_done_nxt;

  logic [ID_W-1:0]   tag_mem      [RES_DEPTH];
  logic [ID_W-1:0]   res_id_mem   [RES_DEPTH];
  logic [DATA_W-1:0] res_data_mem [RES_DEPTH];
  logic [DATA_W-1:0] op_a [NUM_REQ];
  logic [DATA_W-1:0] op_b [NUM_REQ];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RES_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Unpack per-requester operand slices
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
    assign op_a[g] = req_op_a[g*DATA_W +: DATA_W];
    assign op_b[g] = req_op_b[g*DATA_W +: DATA_W];
  end

  // Round-robin search starting at rr_ptr, ascending with wrap
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = RR_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Credits cover in-flight plus buffered results, so the result FIFO cannot overflow
  assign credit_ok = (SUM_W'(inflight) + SUM_W'(res_count)) < SUM_W'(RES_DEPTH);
  assign accept    = grant_vld && grant_en && credit_ok;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  assign done_ok       = add_done && (inflight != '0);
  assign done_bad      = add_done && (inflight == '0);
  assign rsp_pop       = rsp_valid && rsp_ready;
  assign inflight_nxt  = inflight + CNT_W'(accept) - CNT_W'(done_ok);
  assign res_count_nxt = res_count + CNT_W'(done_ok) - CNT_W'(rsp_pop);
  assign drain_empty   = (inflight_nxt == '0) && (res_count_nxt == '0);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (flush)       state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_empty) state_nxt = ST_IDLE;
      ST_IDLE:  if (!flush)      state_nxt = ST_RUN;
      default:                   state_nxt = ST_RUN;
    endcase
  end

  // FSM outputs; flush_done fires in the cycle right after the final pop/completion
  always_comb begin
    grant_en       = 1'b0;
    flush_done_nxt = 1'b0;
    case (state)
      ST_RUN:   grant_en       = 1'b1;
      ST_DRAIN: flush_done_nxt = drain_empty;
      default:  ;
    endcase
  end

  // Issue, tag tracking, result buffering and response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      add_start    <= 1'b0;
      add_a        <= '0;
      add_b        <= '0;
      add_op       <= 1'b0;
      inflight     <= '0;
      res_count    <= '0;
      tag_wr       <= '0;
      tag_rd       <= '0;
      res_wr       <= '0;
      res_rd       <= '0;
      rsp_valid    <= 1'b0;
      flush_done   <= 1'b0;
      err_spurious <= 1'b0;
      for (int unsigned i = 0; i < RES_DEPTH; i++) begin
        tag_mem[i]      <= '0;
        res_id_mem[i]   <= '0;
        res_data_mem[i] <= '0;
      end
    end else begin
      add_start  <= accept;
      flush_done <= flush_done_nxt;
      inflight   <= inflight_nxt;
      res_count  <= res_count_nxt;
      rsp_valid  <= (res_count_nxt != '0);
      if (accept) begin
        rr_ptr          <= (grant_idx == RR_W'(NUM_REQ - 1)) ? '0 : grant_idx + RR_W'(1);
        add_a           <= op_a[grant_idx];
        add_b           <= op_b[grant_idx];
        add_op          <= req_sub[grant_idx];
        tag_mem[tag_wr] <= ID_W'(grant_idx);
        tag_wr          <= ptr_inc(tag_wr);
      end
      if (done_ok) begin
        res_id_mem[res_wr]   <= tag_mem[tag_rd];
        res_data_mem[res_wr] <= add_result;
        res_wr               <= ptr_inc(res_wr);
        tag_rd               <= ptr_inc(tag_rd);
      end
      if (rsp_pop) res_rd <= ptr_inc(res_rd);
      if (done_bad) err_spurious <= 1'b1;
    end
  end

  assign rsp_id   = res_id_mem[res_rd];
  assign rsp_data = res_data_mem[res_rd];

`ifdef FP_ADD_ARB_STATS_EN
  // Saturating accept / stall counters; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else if (stat_clr) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (accept && (stat_issued != 32'hFFFF_FFFF))
        stat_issued <= stat_issued + 32'd1;
      if ((|req_valid) && !accept && (stat_stall != 32'hFFFF_FFFF))
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed testbench for fp_add_arbiter with a fixed-latency adder stub.
module tb_fp_add_arbiter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [127:0]  req_op_a;
  logic [127:0]  req_op_b;
  logic [3:0]    req_sub;
  logic          add_start;
  logic [31:0]   add_a, add_b;
  logic          add_op;
  logic          add_done;
  logic [31:0]   add_result;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_data;
  logic          flush;
  logic          flush_done;
  logic          err_spurious;
`ifdef FP_ADD_ARB_STATS_EN
  logic          stat_clr;
  logic [31:0]   stat_issued, stat_stall;
`endif

  logic [31:0]   opa [4];
  logic [31:0]   opb [4];
  logic [3:0]    tsub;
  logic          inj_done;

  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;

  always #5 clk = ~clk;

  fp_add_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op_a     (req_op_a),
    .req_op_b     (req_op_b),
    .req_sub      (req_sub),
    .add_start    (add_start),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_op       (add_op),
    .add_done     (add_done),
    .add_result   (add_result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .flush        (flush),
    .flush_done   (flush_done),
`ifdef FP_ADD_ARB_STATS_EN
    .stat_clr     (stat_clr),
    .stat_issued  (stat_issued),
    .stat_stall   (stat_stall),
`endif
    .err_spurious (err_spurious)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_op_a[i*32 +: 32] = opa[i];
      req_op_b[i*32 +: 32] = opb[i];
    end
  end
  assign req_sub = tsub;

  // Adder stub: known float vectors plus a bit-mix for everything else
  function automatic logic [31:0] fp_stub(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !op) return 32'h4040_0000;
    if (a == 32'h4040_0000 && b == 32'h3F80_0000 &&  op) return 32'h4000_0000;
    return a ^ b ^ {32{op}};
  endfunction

  // Result expected for requester id under the default operand set
  function automatic logic [31:0] exp_rsp(input logic [1:0] id);
    return opa[id] ^ opb[id] ^ {32{tsub[id]}};
  endfunction

  // Start in cycle C gives add_done in cycle C+2
  logic        s0 = 1'b0, s1 = 1'b0;
  logic [31:0] r0 = '0, r1 = '0;
  always @(posedge clk) begin
    s0 <= add_start;
    s1 <= s0;
    if (add_start) r0 <= fp_stub(add_a, add_b, add_op);
    r1 <= r0;
  end
  assign add_done   = s1 | inj_done;
  assign add_result = r1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_defaults();
    for (int i = 0; i < 4; i++) begin
      opa[i] = 32'hC0DE_0000 + 32'(i) * 32'h111;
      opb[i] = 32'h0000_BEE0 + 32'(i);
    end
    tsub = 4'b1010;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  e_rdy;
    logic [1:0]  e_id;
    logic        seen;

    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1; flush = 1'b0; inj_done = 1'b0;
`ifdef FP_ADD_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    set_defaults();

    // Reset state
    next_cyc(); next_cyc();
    mid();
    chk("rst_ctrl", 64'({add_start, rsp_valid, flush_done, err_spurious}), 64'(0));
    chk("rst_ops",  64'({add_a, add_b, add_op}), 64'(0));
    chk("rst_rsp",  64'({rsp_id, rsp_data}), 64'(0));
    chk("rst_rdy",  64'(req_ready), 64'(0));
    next_cyc();
    rst_n = 1'b1;

    // Fairness from pointer 0, responses one per cycle in issue order
    for (int k = 0; k < 12; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      mid();
      e_rdy = (k < 8) ? 4'(1 << (k % 4)) : 4'h0;
      chk("fair_rdy", 64'(req_ready), 64'(e_rdy));
      if (k >= 4) begin
        e_id = 2'((k - 4) % 4);
        chk("fair_rsp_vld", 64'(rsp_valid), 64'(1));
        chk("fair_rsp_id", 64'(rsp_id), 64'(e_id));
        chk("fair_rsp_data", 64'(rsp_data), 64'(exp_rsp(e_id)));
      end else begin
        chk("fair_rsp_vld", 64'(rsp_valid), 64'(0));
      end
      next_cyc();
    end
    mid();
    chk("fair_empty", 64'(rsp_valid), 64'(0));
    next_cyc();

    // Single request: 1.0 + 2.0 from requester 1
    opa[1] = 32'h3F80_0000; opb[1] = 32'h4000_0000; tsub[1] = 1'b0;
    req_valid = 4'b0010;
    mid();  chk("one_rdy", 64'(req_ready), 64'(4'b0010));
    next_cyc(); req_valid = '0;
    mid();  chk("one_start", 64'({add_start, add_op}), 64'(2'b10));
            chk("one_ops", 64'({add_a, add_b}), {32'h3F80_0000, 32'h4000_0000});
    next_cyc();
    mid();  chk("one_start_off", 64'(add_start), 64'(0));
            chk("one_hold", 64'(add_a), 64'(32'h3F80_0000));
    next_cyc();
    mid();  chk("one_rsp_early", 64'(rsp_valid), 64'(0));
    next_cyc();
    mid();  chk("one_rsp", 64'({rsp_valid, rsp_id, rsp_data}), 64'({1'b1, 2'd1, 32'h4040_0000}));
    next_cyc();
    mid();  chk("one_rsp_gone", 64'(rsp_valid), 64'(0));
    next_cyc();

    // Subtract: 3.0 - 1.0 from requester 2 (pointer now at 2)
    opa[2] = 32'h4040_0000; opb[2] = 32'h3F80_0000; tsub[2] = 1'b1;
    req_valid = 4'b0100;
    mid();  chk("sub_rdy", 64'(req_ready), 64'(4'b0100));
    next_cyc(); req_valid = '0;
    mid();  chk("sub_op", 64'({add_start, add_op}), 64'(2'b11));
    next_cyc(); next_cyc(); next_cyc();
    mid();  chk("sub_rsp", 64'({rsp_valid, rsp_id, rsp_data}), 64'({1'b1, 2'd2, 32'h4000_0000}));
    next_cyc(); next_cyc();
    set_defaults();

    // Backpressure from pointer 3: exactly 8 accepts, then none
    rsp_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      req_valid = 4'hF;
      mid();
      e_rdy = (k < 8) ? 4'(1 << ((3 + k) % 4)) : 4'h0;
      chk("bp_rdy", 64'(req_ready), 64'(e_rdy));
      if (k >= 4) chk("bp_head", 64'({rsp_valid, rsp_id}), 64'({1'b1, 2'd3}));
      next_cyc();
    end
    rsp_ready = 1'b1;
    mid();  chk("bp_full_rdy", 64'(req_ready), 64'(0));
            chk("bp_rsp0", 64'({rsp_id, rsp_data}), 64'({2'd3, exp_rsp(2'd3)}));
    next_cyc();
    for (int j = 1; j <= 8; j++) begin
      req_valid = (j == 1) ? 4'hF : 4'h0;
      mid();
      if (j == 1) chk("bp_resume_rdy", 64'(req_ready), 64'(4'b1000));
      e_id = (j < 8) ? 2'((3 + j) % 4) : 2'd3;
      chk("bp_rsp", 64'({rsp_valid, rsp_id, rsp_data}), 64'({1'b1, e_id, exp_rsp(e_id)}));
      next_cyc();
    end
    mid();  chk("bp_empty", 64'(rsp_valid), 64'(0));
    next_cyc();

    // Flush with 3 ops in flight from pointer 0
    req_valid = 4'hF;
    mid();  chk("fl_rdy0", 64'(req_ready), 64'(4'b0001));
    next_cyc();
    mid();  chk("fl_rdy1", 64'(req_ready), 64'(4'b0010));
    next_cyc(); flush = 1'b1;
    mid();  chk("fl_rdy2", 64'(req_ready), 64'(4'b0100));
    next_cyc();
    for (int m = 3; m <= 8; m++) begin
      mid();
      chk("fl_no_grant", 64'(req_ready), 64'(0));
      chk("fl_done", 64'(flush_done), 64'(m == 7));
      if (m >= 4 && m <= 6) begin
        e_id = 2'(m - 4);
        chk("fl_rsp", 64'({rsp_valid, rsp_id, rsp_data}), 64'({1'b1, e_id, exp_rsp(e_id)}));
      end else begin
        chk("fl_rsp_vld", 64'(rsp_valid), 64'(0));
      end
      next_cyc();
    end
    flush = 1'b0;
    mid();  chk("fl_idle_rdy", 64'(req_ready), 64'(0));
    next_cyc();
    mid();  chk("fl_resume_rdy", 64'(req_ready), 64'(4'b1000));
    next_cyc(); req_valid = '0;
    repeat (6) next_cyc();
    mid();  chk("fl_end", 64'({rsp_valid, flush_done}), 64'(0));
    next_cyc();

    // Spurious completion with nothing in flight
    inj_done = 1'b1;
    mid();  chk("sp_before", 64'(err_spurious), 64'(0));
    next_cyc(); inj_done = 1'b0;
    mid();  chk("sp_set", 64'({err_spurious, rsp_valid}), 64'(2'b10));
    next_cyc(); next_cyc();
    mid();  chk("sp_sticky", 64'(err_spurious), 64'(1));
    next_cyc();

    // Reset mid-stream from pointer 0
    rsp_ready = 1'b0; req_valid = 4'hF;
    next_cyc(); next_cyc(); next_cyc();
    req_valid = '0;
    next_cyc();
    mid();  chk("rm_pre", 64'({rsp_valid, rsp_id}), 64'({1'b1, 2'd0}));
    next_cyc();
    rst_n = 1'b0;
    #1;
    chk("rm_ctrl", 64'({add_start, rsp_valid, flush_done, err_spurious}), 64'(0));
    chk("rm_ops",  64'({add_a, add_b, add_op}), 64'(0));
    chk("rm_rsp",  64'({rsp_id, rsp_data, req_ready}), 64'(0));
    #1;
    rst_n = 1'b1;
    next_cyc();
    mid();  chk("rm_spurious", 64'({err_spurious, rsp_valid}), 64'(2'b10));
    next_cyc(); rsp_ready = 1'b1; req_valid = 4'hF;
    mid();  chk("rm_ptr0", 64'(req_ready), 64'(4'b0001));
    next_cyc(); req_valid = '0;
    repeat (6) next_cyc();

`ifdef FP_ADD_ARB_STATS_EN
    // Statistics: 10 accepts, 5 stalled cycles, then clear
    stat_clr = 1'b1;
    next_cyc(); stat_clr = 1'b0;
    req_valid = 4'b0001;
    repeat (10) next_cyc();
    req_valid = '0; flush = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 30 && !seen; w++) begin
      mid();
      seen = flush_done;
      next_cyc();
    end
    chk("st_drain", 64'(seen), 64'(1));
    req_valid = 4'b0001;
    repeat (5) next_cyc();
    req_valid = '0;
    mid();  chk("st_counts", {stat_issued, stat_stall}, {32'd10, 32'd5});
    next_cyc(); flush = 1'b0; stat_clr = 1'b1;
    next_cyc(); stat_clr = 1'b0;
    mid();  chk("st_clr", {stat_issued, stat_stall}, 64'(0));
    next_cyc();
`else
    seen = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
